// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle mult/multu/div/divu with the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN ends MUL as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mplier, rem, abs_a, abs_b;
  logic [WIDTH:0] rshift, diff;
  logic neg_res, neg_rem, is_div, last, dbz_start;
  assign abs_a = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (!op[0] && b[WIDTH-1]) ? -b : b;
  assign dbz_start = start && op[1] && b == '0;
  // mplier doubles as the dividend/quotient shift register during DIV
  assign rshift = {rem, mplier[WIDTH-1]};
  assign diff = rshift - {1'b0, mcand[WIDTH-1:0]};
  assign busy = state != IDLE;
`ifdef MULDIV_EARLY_OUT_EN
  assign last = (state == MUL) ? mplier[WIDTH-1:1] == '0 : cnt == CNT_W'(WIDTH-1);
`else
  assign last = cnt == CNT_W'(WIDTH-1);
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE: if (start && !dbz_start) next = op[1] ? DIV : MUL;
      MUL, DIV: if (last) next = FIX;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      rem <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          div_by_zero <= dbz_start;
          done <= dbz_start;
          cnt <= '0;
          acc <= '0;
          rem <= '0;
          mcand <= {{WIDTH{1'b0}}, op[1] ? abs_b : abs_a};
          mplier <= op[1] ? abs_a : abs_b;
          neg_res <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem <= !op[0] && a[WIDTH-1];
          is_div <= op[1];
        end else begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        MUL: begin
          acc <= mplier[0] ? acc + mcand : acc;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          rem <= diff[WIDTH] ? rshift[WIDTH-1:0] : diff[WIDTH-1:0];
          mplier <= {mplier[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= neg_res ? -mplier : mplier;
            hi <= neg_rem ? -rem : rem;
          end else begin
            {hi, lo} <= neg_res ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus corner sequences, results checked via a scoreboard queue.
module tb_muldiv_unit;
  logic clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  typedef struct {logic [1:0] op; logic [31:0] a, b, hi, lo;} vec_t;
  typedef struct {logic [31:0] hi, lo; logic dbz; int lat;} exp_t;
  exp_t sb[$];

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int k;
    m = (!o[0] && y[31]) ? -y : y;
    k = 1;
    if (o[1]) return y == 0 ? 0 : 33;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k + 1;
`else
    return (o[1] && y == 0) ? 0 : 33;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic w);
    @(negedge clk);
    op = o; a = x; b = y; start = 1; hi_we = w; wdata = 32'h5555;
    @(negedge clk);
    start = 0; hi_we = 0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name, input int lat0);
    int lat;
    exp_t e;
    lat = lat0;
    e = sb.pop_front();
    if (lat0 == 0 && e.lat > 0) check({name, " busy_start"}, busy, 1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, e.lat);
    check({name, " hi"}, hi, e.hi);
    check({name, " lo"}, lo, e.lo);
    check({name, " dbz"}, div_by_zero, e.dbz);
    check({name, " busy_at_done"}, busy, 0);
    @(negedge clk);
    check({name, " done_pulse"}, done, 0);
    check({name, " idle_after"}, busy, 0);
  endtask

  initial begin
    vec_t tv[10];
    logic [63:0] p;
    logic [1:0] o;
    logic [31:0] x, y;
    tv[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tv[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    tv[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[5] = '{2'd0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    tv[6] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    tv[7] = '{2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tv[8] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tv[9] = '{2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      sb.push_back('{hi: tv[i].hi, lo: tv[i].lo, dbz: 1'b0, lat: lat_of(tv[i].op, tv[i].b)});
      launch(tv[i].op, tv[i].a, tv[i].b, 0);
      wait_done($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i < 4) ? $urandom : $urandom_range(1, 300);
      if (y == 0) y = 1;
      p = model(o, x, y);
      sb.push_back('{hi: p[63:32], lo: p[31:0], dbz: 1'b0, lat: lat_of(o, y)});
      launch(o, x, y, 0);
      wait_done($sformatf("rand%0d", i), 0);
    end

    x = lo;
    @(negedge clk) hi_we = 1; wdata = 32'h12345678;
    @(negedge clk) hi_we = 0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo", lo, x);

    @(negedge clk) hi_we = 1; wdata = 32'h11;
    @(negedge clk) hi_we = 0; lo_we = 1; wdata = 32'h22;
    @(negedge clk) lo_we = 0;
    sb.push_back('{hi: 32'h11, lo: 32'h22, dbz: 1'b1, lat: 0});
    launch(2'd3, 32'd100, 32'd0, 0);
    wait_done("divzero", 0);

    sb.push_back('{hi: 32'h1, lo: 32'h7FFFFFFD, dbz: 1'b0, lat: lat_of(2'd0, 32'h7FFFFFFF)});
    launch(2'd0, 32'd3, 32'h7FFFFFFF, 0);
    repeat (4) @(negedge clk);
    start = 1; op = 2'd3; a = 32'd9; b = 32'd4; hi_we = 1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 0; hi_we = 0;
    check("busy ignore hold hi", hi, 32'h11);
    wait_done("busy ignore", 5);

    @(negedge clk) hi_we = 1; wdata = 32'hAAAA;
    @(negedge clk) hi_we = 0;
    sb.push_back('{hi: 32'h0, lo: 32'h6, dbz: 1'b0, lat: lat_of(2'd0, 32'd3)});
    launch(2'd0, 32'd2, 32'd3, 1);
    check("start beats mthi hi", hi, 32'hAAAA);
    wait_done("start beats mthi", 0);

    launch(2'd0, 32'd5, 32'h7FFFFFFF, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(negedge clk) rst_n = 1;
    sb.push_back('{hi: tv[1].hi, lo: tv[1].lo, dbz: 1'b0, lat: lat_of(tv[1].op, tv[1].b)});
    launch(tv[1].op, tv[1].a, tv[1].b, 0);
    wait_done("after abort", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
